lut_interp_activation: RTL

LUT_INTERP_ACTIVATION -- requirements
Module: lut_interp_activation

---
 rtl/lut_interp_activation_pkg.sv | 15 +
 rtl/lut_interp_table.sv | 52 +++++
 rtl/lut_interp_activation.sv | 87 ++++++++
 3 files changed

// File: rtl/lut_interp_activation_pkg.sv
// Shared activation package: LUT edge-handling encodings and the reset ramp
// that seeds every activation table.
package lut_interp_activation_pkg;

  localparam int EDGE_WRAP           = 0;
  localparam int EDGE_SIGNED_CLAMP   = 1;
  localparam int EDGE_UNSIGNED_CLAMP = 2;

  // Entry i of the reset ramp; the caller truncates to its DATA_W so the
  // upper half of the table reads back as negative values.
  function automatic logic [31:0] ramp_entry(input int idx, input int data_w, input int addr_w);
    return 32'(idx) << (data_w - addr_w);
  endfunction

endpackage

// File: rtl/lut_interp_table.sv
// Activation LUT storage with a write port and combinational base/next
// selection, including the edge behaviour at the top of the index range.
module lut_interp_table
  import lut_interp_activation_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int EDGE_MODE = EDGE_SIGNED_CLAMP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_idx,
  output logic signed [DATA_W-1:0] base_val,
  output logic signed [DATA_W-1:0] next_val
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_IDX     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POS_MAX_IDX = ADDR_W'(DEPTH / 2 - 1);

  logic signed [DATA_W-1:0] lut [DEPTH];
  logic [ADDR_W-1:0]        nidx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut[i] <= DATA_W'(ramp_entry(i, DATA_W, ADDR_W));
      end
    end else if (wr_en) begin
      lut[wr_addr] <= wr_data;
    end
  end

  // idx+1 wraps to 0 naturally at the top; the clamp modes pin the
  // neighbour to the current entry instead.
  always_comb begin
    nidx = rd_idx + ADDR_W'(1);
    if (EDGE_MODE == EDGE_UNSIGNED_CLAMP && rd_idx == TOP_IDX) begin
      nidx = rd_idx;
    end
    if (EDGE_MODE == EDGE_SIGNED_CLAMP && rd_idx == POS_MAX_IDX) begin
      nidx = rd_idx;
    end
  end

  assign base_val = lut[rd_idx];
  assign next_val = lut[nidx];

endmodule

// File: rtl/lut_interp_activation.sv
// Piecewise-linear activation: LUT lookup plus linear interpolation in a
// three-stage valid/ready pipeline that stalls as a whole on backpressure.
module lut_interp_activation
  import lut_interp_activation_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FRAC_W    = 4,
  parameter int EDGE_MODE = EDGE_SIGNED_CLAMP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W+FRAC_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic                     adv;
  logic [ADDR_W-1:0]        idx;
  logic [FRAC_W-1:0]        frac;
  logic signed [DATA_W-1:0] lut_base, lut_next;

  logic                     s1_valid, s2_valid;
  logic signed [DATA_W-1:0] s1_base, s1_next, s2_base;
  logic [FRAC_W-1:0]        s1_frac;
  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod, s2_prod;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign idx      = in_data[ADDR_W+FRAC_W-1:FRAC_W];
  assign frac     = in_data[FRAC_W-1:0];

  lut_interp_table #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .EDGE_MODE(EDGE_MODE)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (idx),
    .base_val(lut_base),
    .next_val(lut_next)
  );

  // frac is unsigned, so it is zero-extended before the signed multiply.
  assign diff = (DATA_W+1)'(s1_next) - (DATA_W+1)'(s1_base);
  assign prod = PROD_W'(diff) * PROD_W'($signed({1'b0, s1_frac}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_base   <= '0;
      s1_next   <= '0;
      s1_frac   <= '0;
      s2_valid  <= 1'b0;
      s2_base   <= '0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_base   <= lut_base;
      s1_next   <= lut_next;
      s1_frac   <= frac;
      s2_valid  <= s1_valid;
      s2_base   <= s1_base;
      s2_prod   <= prod;
      out_valid <= s2_valid;
      // The result always lies between base and next, so wrap-around
      // truncation to DATA_W is exact.
      out_data  <= s2_base + DATA_W'(s2_prod >>> FRAC_W);
    end
  end

endmodule
